// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: single-cycle multiply, 32-iteration restoring
// divide with annul/flush support. Results go to HI/LO through hilo_we.
module ex_muldiv #(
  parameter logic [7:0] OP_MULT  = 8'b00011000,
  parameter logic [7:0] OP_MULTU = 8'b00011001,
  parameter logic [7:0] OP_DIV   = 8'b00011010,
  parameter logic [7:0] OP_DIVU  = 8'b00011011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_reg1,
  input  logic [31:0] ex_reg2,
  input  logic        annul,
  output logic        stallreq,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [1:0]  dbg_state
);

  // Handshake: stallreq=1 means upstream holds its operands; hilo_we is a
  // one-cycle strobe qualifying {hi_o,lo_o}, with no backpressure from HI/LO.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [5:0]  cnt, cnt_d;
  logic [64:0] wreg, wreg_d;
  logic [31:0] divisor, divisor_d;
  logic        sign_a, sign_a_d, sign_b, sign_b_d;
  logic        is_signed, is_signed_d;

  logic        is_div, is_sdiv, is_mult;
  logic [31:0] abs_a, abs_b;
  logic [33:0] trial;
  logic [31:0] quot_raw, rem_raw, quot, rem;
  logic [63:0] prod;

  assign dbg_state = state;

  always_comb begin
    is_div  = (ex_aluop == OP_DIV) || (ex_aluop == OP_DIVU);
    is_sdiv = (ex_aluop == OP_DIV);
    is_mult = (ex_aluop == OP_MULT) || (ex_aluop == OP_MULTU);
    abs_a   = (is_sdiv && ex_reg1[31]) ? (32'd0 - ex_reg1) : ex_reg1;
    abs_b   = (is_sdiv && ex_reg2[31]) ? (32'd0 - ex_reg2) : ex_reg2;
    if (ex_aluop == OP_MULT)
      prod = {{32{ex_reg1[31]}}, ex_reg1} * {{32{ex_reg2[31]}}, ex_reg2};
    else
      prod = {32'd0, ex_reg1} * {32'd0, ex_reg2};
    // 33-bit partial remainder in wreg[64:32]; it can exceed 32 bits when the divisor is large
    trial    = {1'b0, wreg[64:32]} - {2'b00, divisor};
    quot_raw = wreg[31:0];
    rem_raw  = wreg[64:33];
    quot     = (is_signed && (sign_a ^ sign_b)) ? (32'd0 - quot_raw) : quot_raw;
    rem      = (is_signed && sign_a) ? (32'd0 - rem_raw) : rem_raw;
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    wreg_d      = wreg;
    divisor_d   = divisor;
    sign_a_d    = sign_a;
    sign_b_d    = sign_b;
    is_signed_d = is_signed;
    stallreq    = 1'b0;
    hilo_we     = 1'b0;
    hi_o        = 32'd0;
    lo_o        = 32'd0;

    case (state)
      S_IDLE: begin
        if (is_div && !annul) begin
          stallreq = 1'b1;
          if (ex_reg2 == 32'd0) begin
            state_d     = S_BYZERO;
            wreg_d      = 65'd0;
            is_signed_d = 1'b0;
          end else begin
            state_d     = S_ON;
            cnt_d       = 6'd0;
            wreg_d      = {32'd0, abs_a, 1'b0};
            divisor_d   = abs_b;
            sign_a_d    = is_sdiv & ex_reg1[31];
            sign_b_d    = is_sdiv & ex_reg2[31];
            is_signed_d = is_sdiv;
          end
        end else if (is_mult) begin
          hilo_we = 1'b1;
          hi_o    = prod[63:32];
          lo_o    = prod[31:0];
        end
      end
      S_BYZERO: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          stallreq    = 1'b1;
          wreg_d      = 65'd0;
          is_signed_d = 1'b0;
          state_d     = S_END;
        end
      end
      S_ON: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          stallreq = 1'b1;
          if (trial[33])
            wreg_d = {wreg[63:0], 1'b0};
          else
            wreg_d = {trial[31:0], wreg[31:0], 1'b1};
          cnt_d = cnt + 6'd1;
          if (cnt == 6'd31)
            state_d = S_END;
        end
      end
      S_END: begin
        state_d = S_IDLE;
        if (!annul) begin
          hilo_we = 1'b1;
          hi_o    = rem;
          lo_o    = quot;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reset wins over everything, including a combinational multiply result
    if (rst) begin
      stallreq = 1'b0;
      hilo_we  = 1'b0;
      hi_o     = 32'd0;
      lo_o     = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 6'd0;
      wreg      <= 65'd0;
      divisor   <= 32'd0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      is_signed <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      wreg      <= wreg_d;
      divisor   <= divisor_d;
      sign_a    <= sign_a_d;
      sign_b    <= sign_b_d;
      is_signed <= is_signed_d;
    end
  end

endmodule
